// File: rtl/counter_bank_ovr_if.sv
// Bus bundle for the counter bank: per-channel controls in, counters and
// snapshot out. Channel i occupies [2i+1:2i] of mode, bit i of en/wrap/ovr,
// and [WIDTH*i +: WIDTH] of force_val/limit/cnt/snap_cnt.
interface counter_bank_ovr_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]       en;
  logic [2*CHANNELS-1:0]     mode;
  logic [CHANNELS*WIDTH-1:0] force_val;
  logic [CHANNELS*WIDTH-1:0] limit;
  logic                      snap;
  logic [CHANNELS*WIDTH-1:0] cnt;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS-1:0]       ovr;
  logic [CHANNELS*WIDTH-1:0] snap_cnt;
  logic                      snap_valid;

  modport master (
    output en, mode, force_val, limit, snap,
    input  cnt, wrap, ovr, snap_cnt, snap_valid
  );

  modport slave (
    input  en, mode, force_val, limit, snap,
    output cnt, wrap, ovr, snap_cnt, snap_valid
  );
endinterface

// File: rtl/counter_bank_ovr.sv
// Bank of independent up-counters with per-channel override (count, hold,
// force-load, clear), inclusive terminal count with a wrap pulse, and a
// global snapshot that captures every channel's pre-update value together.
module counter_bank_ovr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) (
  input logic                clk,
  input logic                reset,
  counter_bank_ovr_if.slave  bus
);

  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_HOLD  = 2'b01;
  localparam logic [1:0] MODE_FORCE = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  logic [CHANNELS*WIDTH-1:0] cnt_d, cnt_q;
  logic [CHANNELS-1:0]       wrap_d, wrap_q;
  logic [CHANNELS-1:0]       ovr_d, ovr_q;
  logic [CHANNELS*WIDTH-1:0] snap_cnt_d, snap_cnt_q;
  logic                      snap_valid_d, snap_valid_q;

  // One channel's next value, returned as {wrap, cnt}. The >= compare makes a
  // limit lowered beneath the current count wrap on the next enabled cycle,
  // so the counter never runs past limit and cnt+1 cannot overflow.
  function automatic logic [WIDTH:0] next_chan(
    input logic [1:0]       m,
    input logic             e,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] fv,
    input logic [WIDTH-1:0] lim
  );
    logic [WIDTH:0] r;
    r = {1'b0, c};
    case (m)
      MODE_COUNT: begin
        if (e) begin
          if (c >= lim) r = {1'b1, {WIDTH{1'b0}}};
          else          r = {1'b0, c + 1'b1};
        end
      end
      MODE_HOLD:  r = {1'b0, c};
      MODE_FORCE: r = {1'b0, fv};
      MODE_CLEAR: r = {1'b0, {WIDTH{1'b0}}};
      default:    r = {1'b0, c};
    endcase
    return r;
  endfunction

  // Per-channel next state plus snapshot capture of the pre-update counters.
  always_comb begin
    cnt_d        = cnt_q;
    wrap_d       = '0;
    ovr_d        = '0;
    snap_cnt_d   = snap_cnt_q;
    snap_valid_d = bus.snap;
    for (int i = 0; i < CHANNELS; i++) begin
      {wrap_d[i], cnt_d[WIDTH*i +: WIDTH]} = next_chan(
        bus.mode[2*i +: 2], bus.en[i], cnt_q[WIDTH*i +: WIDTH],
        bus.force_val[WIDTH*i +: WIDTH], bus.limit[WIDTH*i +: WIDTH]);
      ovr_d[i] = (bus.mode[2*i +: 2] != MODE_COUNT);
    end
    if (bus.snap) snap_cnt_d = cnt_q;
  end

  // State registers; reset clears every output and overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      wrap_q       <= '0;
      ovr_q        <= '0;
      snap_cnt_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
      ovr_q        <= ovr_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.wrap       = wrap_q;
  assign bus.ovr        = ovr_q;
  assign bus.snap_cnt   = snap_cnt_q;
  assign bus.snap_valid = snap_valid_q;

endmodule

// File: tb/tb_counter_bank_ovr.sv
// Directed bench for counter_bank_ovr (WIDTH=4, CHANNELS=2). Each vector
// drives one cycle of inputs and queues the hand-computed outputs expected
// after the following posedge; a monitor pops and compares them.
module tb_counter_bank_ovr;

  localparam logic [1:0] CNT = 2'b00;
  localparam logic [1:0] HLD = 2'b01;
  localparam logic [1:0] FRC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] wrap;
    logic [1:0] ovr;
    logic [7:0] snap_cnt;
    logic       snap_valid;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  counter_bank_ovr_if #(.WIDTH(4), .CHANNELS(2)) bus ();

  counter_bank_ovr #(.WIDTH(4), .CHANNELS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: the DUT presents a fresh output set after every posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cnt",        bus.cnt,                e.cnt);
        chk("wrap",       {6'd0, bus.wrap},       {6'd0, e.wrap});
        chk("ovr",        {6'd0, bus.ovr},        {6'd0, e.ovr});
        chk("snap_cnt",   bus.snap_cnt,           e.snap_cnt);
        chk("snap_valid", {7'd0, bus.snap_valid}, {7'd0, e.snap_valid});
      end
    end
  end

  task automatic step(
    input logic       r,    input logic [1:0] en,
    input logic [1:0] m1,   input logic [1:0] m0,
    input logic [3:0] f1,   input logic [3:0] f0,
    input logic [3:0] l1,   input logic [3:0] l0,
    input logic       s,
    input logic [3:0] x1,   input logic [3:0] x0,
    input logic [1:0] xw,   input logic [1:0] xo,
    input logic [3:0] xs1,  input logic [3:0] xs0,
    input logic       xsv
  );
    exp_t e;
    @(negedge clk);
    reset         = r;
    bus.en        = en;
    bus.mode      = {m1, m0};
    bus.force_val = {f1, f0};
    bus.limit     = {l1, l0};
    bus.snap      = s;
    e.cnt        = {x1, x0};
    e.wrap       = xw;
    e.ovr        = xo;
    e.snap_cnt   = {xs1, xs0};
    e.snap_valid = xsv;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    bus.en = '0; bus.mode = '0; bus.force_val = '0; bus.limit = '0; bus.snap = 1'b0;

    // 1: reset (with snap/en asserted), then ch0 counts to limit 5 and wraps
    //     r  en     m1   m0   f1 f0 l1  l0 s  x1 x0 wrap   ovr    s1 s0 sv
    step(1, 2'b11, CNT, CNT, 0, 0, 15, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 2, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 3, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 4, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 5, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 15, 5, 0, 0, 2, 2'b00, 2'b00, 0, 0, 0);

    // 2: force ch0 to 9 for three cycles, then resume counting from 9
    step(0, 2'b01, CNT, FRC, 0, 9, 15, 5, 0, 0, 9, 2'b00, 2'b01, 0, 0, 0);
    step(0, 2'b01, CNT, FRC, 0, 9, 15, 5, 0, 0, 9, 2'b00, 2'b01, 0, 0, 0);
    step(0, 2'b01, CNT, FRC, 0, 9, 15, 5, 0, 0, 9, 2'b00, 2'b01, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 9, 15, 15, 0, 0, 10, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 9, 15, 15, 0, 0, 11, 2'b00, 2'b00, 0, 0, 0);

    // 3: ch1 loaded to 7, hold, clear, count to limit 3; ch0 idle at 11
    step(0, 2'b00, FRC, CNT, 7, 0, 3, 15, 0, 7, 11, 2'b00, 2'b10, 0, 0, 0);
    step(0, 2'b00, HLD, CNT, 7, 0, 3, 15, 0, 7, 11, 2'b00, 2'b10, 0, 0, 0);
    step(0, 2'b00, HLD, CNT, 7, 0, 3, 15, 0, 7, 11, 2'b00, 2'b10, 0, 0, 0);
    step(0, 2'b00, CLR, CNT, 7, 0, 3, 15, 0, 0, 11, 2'b00, 2'b10, 0, 0, 0);
    step(0, 2'b10, CNT, CNT, 7, 0, 3, 15, 0, 1, 11, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b10, CNT, CNT, 7, 0, 3, 15, 0, 2, 11, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b10, CNT, CNT, 7, 0, 3, 15, 0, 3, 11, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b10, CNT, CNT, 7, 0, 3, 15, 0, 0, 11, 2'b10, 2'b00, 0, 0, 0);

    // 4: ch0 12 -> limit lowered to 4 wraps at once; limit 0 wraps every cycle
    step(0, 2'b01, CNT, CNT, 0, 0, 3, 15, 0, 0, 12, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 3, 4,  0, 0, 0,  2'b01, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 3, 0,  0, 0, 0,  2'b01, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 3, 0,  0, 0, 0,  2'b01, 2'b00, 0, 0, 0);
    step(0, 2'b01, CNT, CNT, 0, 0, 3, 0,  0, 0, 0,  2'b01, 2'b00, 0, 0, 0);

    // 5: load {8,3}, count with two back-to-back snapshots, then hold snapshot
    step(0, 2'b11, FRC, FRC, 8, 3, 15, 15, 0, 8, 3, 2'b00, 2'b11, 0, 0, 0);
    step(0, 2'b11, CNT, CNT, 8, 3, 15, 15, 1, 9, 4, 2'b00, 2'b00, 8, 3, 1);
    step(0, 2'b11, CNT, CNT, 8, 3, 15, 15, 1, 10, 5, 2'b00, 2'b00, 9, 4, 1);
    step(0, 2'b11, CNT, CNT, 8, 3, 15, 15, 0, 11, 6, 2'b00, 2'b00, 9, 4, 0);
    step(0, 2'b11, CNT, CNT, 8, 3, 15, 15, 0, 12, 7, 2'b00, 2'b00, 9, 4, 0);

    // 6: mid-run reset with snap, force and enable asserted; restart from 0
    step(1, 2'b11, CNT, FRC, 0, 6, 15, 15, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b11, CNT, CNT, 0, 6, 15, 15, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b11, CNT, CNT, 0, 6, 15, 15, 0, 2, 2, 2'b00, 2'b00, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
